// File: rtl/mem_b_reader.sv
// mem_b_reader: streams len_i words from RAM port B, starting at base_i, onto a valid/ready stream.
// Optional abort port is compiled in when MEM_B_READER_ABORT_EN is defined.
module mem_b_reader #(
    parameter int G_ADDR_WIDTH = 10,
    parameter int G_DATA_WIDTH = 8
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    start_i,
    input  logic [G_ADDR_WIDTH-1:0] base_i,
    input  logic [G_ADDR_WIDTH:0]   len_i,
`ifdef MEM_B_READER_ABORT_EN
    input  logic                    abort_i,
`endif
    output logic                    busy_o,
    output logic                    done_o,
    output logic [G_ADDR_WIDTH-1:0] mem_adr_o,
    output logic                    mem_rd_o,
    input  logic [G_DATA_WIDTH-1:0] mem_dat_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [G_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic [1:0]              state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [G_ADDR_WIDTH-1:0] ADR_ONE  = G_ADDR_WIDTH'(1);
    localparam logic [G_ADDR_WIDTH:0]   LEN_ONE  = (G_ADDR_WIDTH + 1)'(1);
    localparam logic [G_ADDR_WIDTH:0]   LEN_ZERO = '0;

    state_t                    state_q, state_d;
    logic [G_ADDR_WIDTH-1:0]   adr_q;
    logic [G_ADDR_WIDTH:0]     iss_rem_q;
    logic [G_ADDR_WIDTH:0]     out_rem_q;
    logic                      inflight_q;
    logic                      done_q;
    logic [G_DATA_WIDTH-1:0]   fifo_q [2];
    logic                      wr_ptr_q, rd_ptr_q;
    logic [1:0]                count_q, count_d;

    logic                      abort_w;
    logic                      push, pop, issue;
    logic                      load, zero_len_start, last_accept;
    logic [2:0]                occ_after_pop;

`ifdef MEM_B_READER_ABORT_EN
    assign abort_w = abort_i && (state_q != S_IDLE);
`else
    assign abort_w = 1'b0;
`endif

    // Stream handshake: a word moves when m_valid_o & m_ready_i are both high at a rising edge;
    // once m_valid_o is raised, it and m_data_o hold until that transfer happens.
    assign m_valid_o = (count_q != 2'd0);
    assign pop       = m_valid_o && m_ready_i;
    assign push      = inflight_q;

    // Occupancy counts the word leaving this cycle as gone, which is what sustains one word per cycle.
    assign occ_after_pop = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue         = (state_q == S_RUN) && !abort_w && (occ_after_pop < 3'd2);

    assign load           = (state_q == S_IDLE) && start_i && (len_i != LEN_ZERO);
    assign zero_len_start = (state_q == S_IDLE) && start_i && (len_i == LEN_ZERO);
    assign last_accept    = (state_q == S_DRAIN) && pop && (out_rem_q == LEN_ONE) && !abort_w;

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = done_q;
    assign mem_adr_o = adr_q;
    assign mem_rd_o  = issue;
    assign m_data_o  = fifo_q[rd_ptr_q];
    assign m_last_o  = m_valid_o && (out_rem_q == LEN_ONE);
    assign state_o   = state_q;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (issue && (iss_rem_q == LEN_ONE)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && (out_rem_q == LEN_ONE)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_w) begin
            state_d = S_IDLE;
        end
    end

    // Address and counters; iss_rem counts reads still to issue, out_rem words still to deliver.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            adr_q      <= '0;
            iss_rem_q  <= '0;
            out_rem_q  <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= issue;
            done_q     <= zero_len_start || last_accept;
            if (load) begin
                adr_q     <= base_i;
                iss_rem_q <= len_i;
                out_rem_q <= len_i;
            end else begin
                if (issue) begin
                    adr_q     <= adr_q + ADR_ONE;
                    iss_rem_q <= iss_rem_q - LEN_ONE;
                end
                if (pop) begin
                    out_rem_q <= out_rem_q - LEN_ONE;
                end
            end
            if (abort_w) begin
                iss_rem_q <= '0;
                out_rem_q <= '0;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Two-entry FIFO; an abort drops both buffered words and the word returning from RAM.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else if (abort_w) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_dat_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_mem_b_reader.sv
// Bench for mem_b_reader: RAM model, randomized transfers and ready patterns, queue-based model.
// Abort scenario is compiled in when MEM_B_READER_ABORT_EN is defined.
module tb_mem_b_reader;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          aclk = 1'b0;
  logic          areset_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_i = '0;
  logic [AW:0]   len_i = '0;
  logic          busy_o, done_o, mem_rd_o, m_valid_o, m_last_o;
  logic          m_ready_i = 1'b0;
  logic [AW-1:0] mem_adr_o;
  logic [DW-1:0] mem_dat_i = '0;
  logic [DW-1:0] m_data_o;
  logic [1:0]    state_o;
`ifdef MEM_B_READER_ABORT_EN
  logic          abort_i = 1'b0;
`endif

  mem_b_reader #(.G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW)) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .start_i   (start_i),
    .base_i    (base_i),
    .len_i     (len_i),
`ifdef MEM_B_READER_ABORT_EN
    .abort_i   (abort_i),
`endif
    .busy_o    (busy_o),
    .done_o    (done_o),
    .mem_adr_o (mem_adr_o),
    .mem_rd_o  (mem_rd_o),
    .mem_dat_i (mem_dat_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_last_o  (m_last_o),
    .state_o   (state_o)
  );

  // ---------------- clock / RAM model ----------------
  always #5 aclk = ~aclk;

  logic [DW-1:0] ram [DEPTH];
  always @(posedge aclk) if (mem_rd_o) mem_dat_i <= ram[mem_adr_o];

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_adr_q[$];
  logic [DW-1:0] obs_dat[$];
  logic [AW-1:0] obs_adr[$];
  bit            m_busy, m_done, stall_prev, nb, nd, hs;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] a;
  int            checks, errors, ncyc, n_rd, n_acc, done_cnt, valid_cnt;
  int            start_cyc, first_valid_cyc, last_cyc, done_cyc;
  int            ready_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        0:       m_ready_i = 1'b1;
        1:       m_ready_i = ~m_ready_i;
        default: m_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge aclk);
      ncyc++;
      if (!areset_n) begin
        exp_q.delete(); exp_adr_q.delete();
        m_busy = 0; m_done = 0; stall_prev = 0; n_rd = 0; n_acc = 0;
        continue;
      end
      check("busy", busy_o, m_busy);
      check("done", done_o, m_done);
      if (done_o) begin done_cnt++; done_cyc = ncyc; end
      if (mem_rd_o) begin
        if (exp_adr_q.size() == 0) check("spurious_rd", 1, 0);
        else check("rd_addr", mem_adr_o, exp_adr_q.pop_front());
        obs_adr.push_back(mem_adr_o);
        n_rd++;
      end
      if (stall_prev) begin
        check("stall_valid_hold", m_valid_o, 1);
        if (m_valid_o) check("stall_data_hold", m_data_o, prev_data);
      end
      if (m_valid_o) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = ncyc;
        if (exp_q.size() == 0) check("spurious_valid", 1, 0);
        else begin
          check("data", m_data_o, exp_q[0]);
          check("last", m_last_o, exp_q.size() == 1);
        end
      end else begin
        check("last_without_valid", m_last_o, 0);
      end
      hs = m_valid_o && m_ready_i;
      nb = m_busy;
      nd = 0;
      if (hs && exp_q.size() > 0) begin
        obs_dat.push_back(m_data_o);
        last_cyc = ncyc;
        n_acc++;
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          nb = 0; nd = 1;
          check("all_reads_issued", exp_adr_q.size(), 0);
        end
      end
      if (mem_rd_o) check("occupancy_le_2", (n_rd - n_acc) <= 2, 1);
      if (!m_busy && start_i) begin
        start_cyc = ncyc; first_valid_cyc = -1; n_rd = 0; n_acc = 0;
        if (len_i == 0) nd = 1;
        else begin
          nb = 1;
          for (int k = 0; k < int'(len_i); k++) begin
            a = base_i + AW'(k);
            exp_adr_q.push_back(a);
            exp_q.push_back(ram[a]);
          end
        end
      end
      stall_prev = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
`ifdef MEM_B_READER_ABORT_EN
      if (abort_i && m_busy) begin
        nb = 0; nd = 0; stall_prev = 0;
        exp_q.delete(); exp_adr_q.delete(); n_rd = 0; n_acc = 0;
      end
`endif
      m_busy = nb;
      m_done = nd;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input int b, input int l);
    @(posedge aclk);
    #1;
    base_i  = AW'(b);
    len_i   = (AW + 1)'(l);
    start_i = 1'b1;
    @(posedge aclk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      @(posedge aclk);
      n++;
    end
    check("xfer_complete", m_busy, 0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic wait_words(input int words, input int budget);
    int n = 0;
    while (obs_dat.size() < words && n < budget) begin
      @(posedge aclk);
      n++;
    end
    check("words_reached", obs_dat.size() >= words, 1);
  endtask

  task automatic clear_obs();
    obs_dat.delete();
    obs_adr.delete();
    done_cyc = -1;
  endtask

  // ---------------- main sequence ----------------
  int dcnt, vcnt, l;
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
    ready_mode = 0;
    first_valid_cyc = -1;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rd", mem_rd_o, 0);
    check("rst_valid", m_valid_o, 0);
    check("rst_last", m_last_o, 0);
    check("rst_adr", mem_adr_o, 0);
    check("rst_data", m_data_o, 0);
    repeat (3) @(posedge aclk);
    #2 areset_n = 1'b1;
    repeat (2) @(posedge aclk);

    // base 0x010, len 4, ready held high
    ram[16] = 8'hA1; ram[17] = 8'hA2; ram[18] = 8'hA3; ram[19] = 8'hA4;
    clear_obs();
    start_xfer(16, 4);
    wait_idle(50);
    check("basic_words", obs_dat.size(), 4);
    if (obs_dat.size() == 4) begin
      check("basic_w0", obs_dat[0], 8'hA1);
      check("basic_w1", obs_dat[1], 8'hA2);
      check("basic_w2", obs_dat[2], 8'hA3);
      check("basic_w3", obs_dat[3], 8'hA4);
    end
    // rising edges after the one that samples start_i
    check("first_valid_latency", first_valid_cyc - start_cyc - 1, 2);
    check("back_to_back", last_cyc - first_valid_cyc, 3);
    check("done_after_last", done_cyc - last_cyc, 1);

    // address wrap
    clear_obs();
    start_xfer(10'h3FE, 4);
    wait_idle(50);
    check("wrap_reads", obs_adr.size(), 4);
    if (obs_adr.size() == 4) begin
      check("wrap_a0", obs_adr[0], 10'h3FE);
      check("wrap_a1", obs_adr[1], 10'h3FF);
      check("wrap_a2", obs_adr[2], 10'h000);
      check("wrap_a3", obs_adr[3], 10'h001);
    end

    // len 8 with ready toggling each cycle
    ready_mode = 1;
    clear_obs();
    start_xfer(10'h123, 8);
    wait_idle(100);
    check("toggle_words", obs_dat.size(), 8);
    ready_mode = 0;

    // zero length, then a start while busy
    clear_obs();
    dcnt = done_cnt;
    vcnt = valid_cnt;
    start_xfer(10'h050, 0);
    repeat (3) @(posedge aclk);
    check("zero_len_done", done_cnt, dcnt + 1);
    check("zero_len_no_rd", obs_adr.size(), 0);
    check("zero_len_no_valid", valid_cnt, vcnt);
    clear_obs();
    start_xfer(10'h200, 5);
    @(posedge aclk);
    #1;
    base_i = 10'h000; len_i = 11'd3; start_i = 1'b1;
    @(posedge aclk);
    #1 start_i = 1'b0;
    wait_idle(50);
    check("busy_start_ignored", obs_dat.size(), 5);

    // reset during word 3 of a 10-word transfer
    clear_obs();
    start_xfer(10'h100, 10);
    wait_words(2, 50);
    #3 areset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_done", done_o, 0);
    check("mid_rst_rd", mem_rd_o, 0);
    check("mid_rst_valid", m_valid_o, 0);
    check("mid_rst_last", m_last_o, 0);
    check("mid_rst_adr", mem_adr_o, 0);
    check("mid_rst_data", m_data_o, 0);
    repeat (2) @(posedge aclk);
    #2 areset_n = 1'b1;
    dcnt = done_cnt;
    vcnt = valid_cnt;
    repeat (20) @(posedge aclk);
    check("post_rst_no_done", done_cnt, dcnt);
    check("post_rst_no_valid", valid_cnt, vcnt);

`ifdef MEM_B_READER_ABORT_EN
    // abort at word 2 of 16, then a normal transfer
    clear_obs();
    dcnt = done_cnt;
    start_xfer(10'h050, 16);
    wait_words(1, 50);
    #1 abort_i = 1'b1;
    @(posedge aclk);
    #1 abort_i = 1'b0;
    check("abort_valid_drop", m_valid_o, 0);
    check("abort_busy_drop", busy_o, 0);
    repeat (5) @(posedge aclk);
    check("abort_no_done", done_cnt, dcnt);
    clear_obs();
    start_xfer(10'h060, 2);
    wait_idle(50);
    check("post_abort_words", obs_dat.size(), 2);
`endif

    // randomized transfers
    for (int t = 0; t < 14; t++) begin
      ready_mode = $urandom_range(0, 2);
      for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
      l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      clear_obs();
      start_xfer($urandom_range(0, DEPTH - 1), l);
      wait_idle(400);
      check("rand_words", obs_dat.size(), l);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
